// File: rtl/gemm_sequencer.sv
// Control sequencer for an N x N output-stationary GEMM systolic array:
// accumulator clear, row-skewed compute enables, feeder strobes and result drain.
module gemm_sequencer #(
    parameter int ARRAY_N = 16,
    parameter int K_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [K_W-1:0]               k_len,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   pe_state,
    output logic                         sync_reset,
    output logic [ARRAY_N-1:0]           gemm_valid,
    output logic                         feed_en,
    output logic [K_W-1:0]               feed_idx,
    output logic                         drain_valid,
    output logic [$clog2(ARRAY_N)-1:0]   drain_row
);
    localparam int ROW_W = $clog2(ARRAY_N);
    // Wide enough for K+ARRAY_N-1, and for the negative row offsets to wrap above any K.
    localparam int CNT_W = K_W + ROW_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [K_W-1:0]   k_reg, k_next;
    logic [1:0]       mode_reg, mode_next;
    logic             err_next;
    logic [CNT_W-1:0] k_ext;
    logic [CNT_W-1:0] compute_last;
    logic [ARRAY_N-1:0] gemm_valid_next;

    assign compute_last = CNT_W'(k_reg) + CNT_W'(ARRAY_N) - CNT_W'(2);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        k_next     = k_reg;
        mode_next  = mode_reg;
        err_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (mode == 2'b00 && k_len != '0) begin
                        state_next = S_CLEAR;
                        k_next     = k_len;
                        mode_next  = mode;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_next = S_COMPUTE;
                cnt_next   = '0;
            end
            S_COMPUTE: begin
                if (cnt_reg == compute_last) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_reg == CNT_W'(ARRAY_N - 1)) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Cancel overrides any counter progress; the flush cycle re-clears the PEs.
        if (abort && state_reg != S_IDLE) begin
            state_next = S_FLUSH;
        end
    end

    assign k_ext = CNT_W'(k_next);

    // Row r is enabled while 0 <= c - r < K; a negative offset wraps above any K.
    generate
        for (genvar gi = 0; gi < ARRAY_N; gi++) begin : g_row
            logic [CNT_W-1:0] row_ofs;
            assign row_ofs = cnt_next - CNT_W'(gi);
            assign gemm_valid_next[gi] = (state_next == S_COMPUTE) && (row_ofs < k_ext);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            k_reg       <= '0;
            mode_reg    <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            pe_state    <= 2'b00;
            sync_reset  <= 1'b0;
            gemm_valid  <= '0;
            feed_en     <= 1'b0;
            feed_idx    <= '0;
            drain_valid <= 1'b0;
            drain_row   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            k_reg       <= k_next;
            mode_reg    <= mode_next;
            busy        <= (state_next != S_IDLE);
            done        <= (state_next == S_DONE);
            err         <= err_next;
            pe_state    <= (state_next != S_IDLE) ? mode_next : 2'b00;
            sync_reset  <= (state_next == S_CLEAR) || (state_next == S_FLUSH);
            gemm_valid  <= gemm_valid_next;
            feed_en     <= gemm_valid_next[0];
            feed_idx    <= gemm_valid_next[0] ? cnt_next[K_W-1:0] : '0;
            drain_valid <= (state_next == S_DRAIN);
            drain_row   <= (state_next == S_DRAIN) ? cnt_next[ROW_W-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_gemm_sequencer.sv
// Directed bench for gemm_sequencer: per-cycle output checks against the
// documented cycle timing for legal, illegal, aborted, chained and reset jobs.
module tb_gemm_sequencer;
    localparam int N   = 16;
    localparam int K_W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [K_W-1:0] k_len = '0;
    logic           abort = 1'b0;
    logic           busy, done, err, sync_reset, feed_en, drain_valid;
    logic [1:0]     pe_state;
    logic [N-1:0]   gemm_valid;
    logic [K_W-1:0] feed_idx;
    logic [3:0]     drain_row;

    int n_vec  = 0;
    int n_miss = 0;

    gemm_sequencer #(.ARRAY_N(N), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .k_len(k_len),
        .abort(abort), .busy(busy), .done(done), .err(err), .pe_state(pe_state),
        .sync_reset(sync_reset), .gemm_valid(gemm_valid), .feed_en(feed_en),
        .feed_idx(feed_idx), .drain_valid(drain_valid), .drain_row(drain_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s busy", tag), 32'(busy), 0);
        check($sformatf("%s done", tag), 32'(done), 0);
        check($sformatf("%s err", tag), 32'(err), 0);
        check($sformatf("%s sync_reset", tag), 32'(sync_reset), 0);
        check($sformatf("%s gemm_valid", tag), 32'(gemm_valid), 0);
        check($sformatf("%s feed_en", tag), 32'(feed_en), 0);
        check($sformatf("%s feed_idx", tag), 32'(feed_idx), 0);
        check($sformatf("%s drain_valid", tag), 32'(drain_valid), 0);
        check($sformatf("%s drain_row", tag), 32'(drain_row), 0);
        check($sformatf("%s pe_state", tag), 32'(pe_state), 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; that cycle is cycle 0 of the job.
    // Returns in the done cycle, or in the cycle after the flush when aborted.
    task automatic run_job(input int k, input bit noise, input int abort_at);
        int last;
        logic [N-1:0] exp_gv;
        bit fe, dv;
        last  = k + 2 * N + 1;
        start = 1'b1;
        k_len = K_W'(k);
        mode  = 2'b00;
        next_cycle();
        start = 1'b0;
        for (int t = 1; t <= last; t++) begin
            for (int r = 0; r < N; r++) exp_gv[r] = (t >= 2 + r) && (t <= 1 + r + k);
            fe = (t >= 2) && (t <= k + 1);
            dv = (t >= k + N + 1) && (t <= k + 2 * N);
            check($sformatf("K%0d t%0d busy", k, t), 32'(busy), 1);
            check($sformatf("K%0d t%0d sync_reset", k, t), 32'(sync_reset), 32'(t == 1));
            check($sformatf("K%0d t%0d feed_en", k, t), 32'(feed_en), 32'(fe));
            if (fe) check($sformatf("K%0d t%0d feed_idx", k, t), 32'(feed_idx), 32'(t - 2));
            check($sformatf("K%0d t%0d gemm_valid", k, t), 32'(gemm_valid), 32'(exp_gv));
            check($sformatf("K%0d t%0d drain_valid", k, t), 32'(drain_valid), 32'(dv));
            if (dv) check($sformatf("K%0d t%0d drain_row", k, t), 32'(drain_row), 32'(t - k - N - 1));
            check($sformatf("K%0d t%0d done", k, t), 32'(done), 32'(t == last));
            check($sformatf("K%0d t%0d err", k, t), 32'(err), 0);
            check($sformatf("K%0d t%0d pe_state", k, t), 32'(pe_state), 0);
            if (abort_at != 0 && t == abort_at) begin
                abort = 1'b1;
                next_cycle();
                abort = 1'b0;
                check("abort flush sync_reset", 32'(sync_reset), 1);
                check("abort flush gemm_valid", 32'(gemm_valid), 0);
                check("abort flush feed_en", 32'(feed_en), 0);
                check("abort flush drain_valid", 32'(drain_valid), 0);
                check("abort flush done", 32'(done), 0);
                next_cycle();
                check_all_zero("abort idle");
                for (int i = 0; i < 40; i++) begin
                    next_cycle();
                    check("abort no done", 32'(done), 0);
                end
                return;
            end
            if (t == last) break;
            start = noise && (t < k + 2 * N) && (t % 2 == 1);
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic illegal_start(input int k, input logic [1:0] m);
        start = 1'b1;
        k_len = K_W'(k);
        mode  = m;
        next_cycle();
        start = 1'b0;
        mode  = 2'b00;
        check($sformatf("illegal K%0d m%0d err", k, m), 32'(err), 1);
        check($sformatf("illegal K%0d m%0d busy", k, m), 32'(busy), 0);
        check($sformatf("illegal K%0d m%0d sync_reset", k, m), 32'(sync_reset), 0);
        next_cycle();
        check($sformatf("illegal K%0d m%0d err cleared", k, m), 32'(err), 0);
        check($sformatf("illegal K%0d m%0d still idle", k, m), 32'(busy), 0);
        check($sformatf("illegal K%0d m%0d no clear", k, m), 32'(sync_reset), 0);
    endtask

    initial begin
        #2;
        check_all_zero("in reset");
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        check_all_zero("after reset");

        // Basic job, K=4: done in cycle 37
        run_job(4, 1'b0, 0);
        next_cycle();
        check("K4 idle after done", 32'(busy), 0);

        illegal_start(0, 2'b00);
        illegal_start(3, 2'b01);

        // K=255: feed_idx tops out at 254, done in cycle 288
        run_job(255, 1'b0, 0);
        next_cycle();

        // Abort in cycle 10 of a K=20 job
        run_job(20, 1'b0, 10);

        // Extra start pulses ignored, then back-to-back start one cycle after done
        run_job(6, 1'b1, 0);
        next_cycle();
        check("chain idle gap busy", 32'(busy), 0);
        run_job(3, 1'b0, 0);
        next_cycle();

        // Asynchronous reset in mid-drain of a K=4 job
        start = 1'b1;
        k_len = 8'd4;
        next_cycle();
        start = 1'b0;
        repeat (24) next_cycle();
        check("pre-reset drain_valid", 32'(drain_valid), 1);
        check("pre-reset drain_row", 32'(drain_row), 4);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        check_all_zero("post reset idle");
        run_job(1, 1'b0, 0);
        next_cycle();
        check("K1 idle after done", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
